// File: rtl/clock_reset_sequencer_if.sv
// Bundles the lock/request inputs and the six reset pairs plus status flags
// that connect the sequencer to the clocks/resets slave bridge.
interface clock_reset_sequencer_if;
  logic i_soft_reset_req;
  logic i_design_locked;
  logic i_mem_ready;

  logic o_host_interconnect_reset;
  logic o_host_interconnect_resetn;
  logic o_mem_interconnect_reset;
  logic o_mem_interconnect_resetn;
  logic o_design_interconnect_reset;
  logic o_design_interconnect_resetn;
  logic o_host_peripheral_reset;
  logic o_host_peripheral_resetn;
  logic o_mem_peripheral_reset;
  logic o_mem_peripheral_resetn;
  logic o_design_peripheral_reset;
  logic o_design_peripheral_resetn;

  logic o_busy;
  logic o_done;
  logic o_timeout;

  // Sequencer side
  modport master (
    input  i_soft_reset_req, i_design_locked, i_mem_ready,
    output o_host_interconnect_reset, o_host_interconnect_resetn,
           o_mem_interconnect_reset, o_mem_interconnect_resetn,
           o_design_interconnect_reset, o_design_interconnect_resetn,
           o_host_peripheral_reset, o_host_peripheral_resetn,
           o_mem_peripheral_reset, o_mem_peripheral_resetn,
           o_design_peripheral_reset, o_design_peripheral_resetn,
           o_busy, o_done, o_timeout
  );

  // Consumer side (bridge / lock sources)
  modport slave (
    output i_soft_reset_req, i_design_locked, i_mem_ready,
    input  o_host_interconnect_reset, o_host_interconnect_resetn,
           o_mem_interconnect_reset, o_mem_interconnect_resetn,
           o_design_interconnect_reset, o_design_interconnect_resetn,
           o_host_peripheral_reset, o_host_peripheral_resetn,
           o_mem_peripheral_reset, o_mem_peripheral_resetn,
           o_design_peripheral_reset, o_design_peripheral_resetn,
           o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Reset sequencer for the host/memory/design reset pairs.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ASSERT    | all resets asserted, counting the minimum hold time
//   WAIT_LOCK | hold done, waiting for MMCM lock and memory calibration
//   RELEASE   | releasing one reset per STAGE_GAP cycles, fixed order
//   DONE      | all resets released; lock loss restarts the sequence
//   ERROR     | lock wait timed out; resets held until soft/hard reset
//
// Release mask bit order: 0 host_ic, 1 mem_ic, 2 design_ic,
// 3 host_periph, 4 mem_periph, 5 design_periph. reset = ~mask, resetn = mask.
module clock_reset_sequencer #(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  clock_reset_sequencer_if.master        bus
);

  localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_HG > LOCK_TIMEOUT) ? MAX_HG : LOCK_TIMEOUT;
  localparam int CW     = ($clog2(MAX_C) < 1) ? 1 : $clog2(MAX_C);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_ASSERT    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [5:0]      mask_q;
  logic            busy_q;
  logic            done_q;
  logic            timeout_q;
  logic            locks_ok;

  assign locks_ok = bus.i_design_locked & bus.i_mem_ready;

  // Sequencer FSM: priority is hard reset, soft request, lock loss, progression
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_ASSERT;
      cnt_q     <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (bus.i_soft_reset_req) begin
      state_q   <= S_ASSERT;
      cnt_q     <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if ((state_q == S_RELEASE || state_q == S_DONE) && !locks_ok) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          mask_q <= '0;
          if (cnt_q == HOLD_LAST) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (locks_ok) begin
            state_q <= S_RELEASE;
            mask_q  <= 6'b000001;
            cnt_q   <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q   <= S_ERROR;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (mask_q[5]) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              mask_q <= {mask_q[4:0], 1'b1};
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          mask_q <= 6'b111111;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        S_ERROR: begin
          mask_q    <= '0;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          timeout_q <= 1'b1;
        end
        default: begin
          state_q <= S_ASSERT;
          cnt_q   <= '0;
          mask_q  <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reset pairs are straight inversions of the registered mask, so reset == ~resetn always
  assign bus.o_host_interconnect_reset    = ~mask_q[0];
  assign bus.o_host_interconnect_resetn   =  mask_q[0];
  assign bus.o_mem_interconnect_reset     = ~mask_q[1];
  assign bus.o_mem_interconnect_resetn    =  mask_q[1];
  assign bus.o_design_interconnect_reset  = ~mask_q[2];
  assign bus.o_design_interconnect_resetn =  mask_q[2];
  assign bus.o_host_peripheral_reset      = ~mask_q[3];
  assign bus.o_host_peripheral_resetn     =  mask_q[3];
  assign bus.o_mem_peripheral_reset       = ~mask_q[4];
  assign bus.o_mem_peripheral_resetn      =  mask_q[4];
  assign bus.o_design_peripheral_reset    = ~mask_q[5];
  assign bus.o_design_peripheral_resetn   =  mask_q[5];

  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench: DUT A uses default parameters, DUT B uses LOCK_TIMEOUT=64.
// Cycle 0 is the first cycle with reset low; outputs sampled on the falling edge.
module tb_clock_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  clock_reset_sequencer_if ifa ();
  clock_reset_sequencer_if ifb ();

  clock_reset_sequencer u_a (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifa.master)
  );

  clock_reset_sequencer #(.LOCK_TIMEOUT(64)) u_b (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifb.master)
  );

  logic [5:0] a_rst, a_rstn, b_rst, b_rstn;
  assign a_rst  = {ifa.o_design_peripheral_reset, ifa.o_mem_peripheral_reset,
                   ifa.o_host_peripheral_reset, ifa.o_design_interconnect_reset,
                   ifa.o_mem_interconnect_reset, ifa.o_host_interconnect_reset};
  assign a_rstn = {ifa.o_design_peripheral_resetn, ifa.o_mem_peripheral_resetn,
                   ifa.o_host_peripheral_resetn, ifa.o_design_interconnect_resetn,
                   ifa.o_mem_interconnect_resetn, ifa.o_host_interconnect_resetn};
  assign b_rst  = {ifb.o_design_peripheral_reset, ifb.o_mem_peripheral_reset,
                   ifb.o_host_peripheral_reset, ifb.o_design_interconnect_reset,
                   ifb.o_mem_interconnect_reset, ifb.o_host_interconnect_reset};
  assign b_rstn = {ifb.o_design_peripheral_resetn, ifb.o_mem_peripheral_resetn,
                   ifb.o_host_peripheral_resetn, ifb.o_design_interconnect_resetn,
                   ifb.o_mem_interconnect_resetn, ifb.o_host_interconnect_resetn};

  // Every cycle, every pair: reset must be the complement of resetn
  always @(negedge clk) begin
    checks++;
    if (a_rst !== ~a_rstn) begin
      errors++;
      $display("FAIL pair_invariant dut=A rst=%b rstn=%b", a_rst, a_rstn);
    end
    checks++;
    if (b_rst !== ~b_rstn) begin
      errors++;
      $display("FAIL pair_invariant dut=B rst=%b rstn=%b", b_rst, b_rstn);
    end
  end

  typedef struct {
    int         cyc;
    bit         dut;
    logic       lk;
    logic       mr;
    logic       sr;
    logic [5:0] rst;
    logic       busy;
    logic       done;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int c, bit d, logic lk, logic mr, logic sr,
                              logic [5:0] r, logic b, logic dn, logic t);
    vec_t v;
    v.cyc = c; v.dut = d; v.lk = lk; v.mr = mr; v.sr = sr;
    v.rst = r; v.busy = b; v.done = dn; v.tmo = t;
    tbl.push_back(v);
  endfunction

  task automatic set_in(input bit d, input logic lk, input logic mr);
    if (!d) begin
      ifa.i_design_locked = lk; ifa.i_mem_ready = mr;
    end else begin
      ifb.i_design_locked = lk; ifb.i_mem_ready = mr;
    end
  endtask

  task automatic do_reset(input logic sr);
    rst = 1'b1;
    ifa.i_soft_reset_req = sr;
    ifb.i_soft_reset_req = sr;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ifa.i_soft_reset_req = 1'b0;
    ifb.i_soft_reset_req = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string name);
    logic [5:0] r;
    logic b, dn, t;
    if (!v.dut) begin
      r = a_rst; b = ifa.o_busy; dn = ifa.o_done; t = ifa.o_timeout;
    end else begin
      r = b_rst; b = ifb.o_busy; dn = ifb.o_done; t = ifb.o_timeout;
    end
    checks++;
    if ({r, b, dn, t} !== {v.rst, v.busy, v.done, v.tmo}) begin
      errors++;
      $display("FAIL %s cyc=%0d dut=%0d got rst=%b busy=%b done=%b tmo=%b want rst=%b busy=%b done=%b tmo=%b",
               name, v.cyc, v.dut, r, b, dn, t, v.rst, v.busy, v.done, v.tmo);
    end
  endtask

  // Walks cycles 0..ncyc-1: applies each row's inputs at the start of its
  // cycle, checks the row's outputs on the falling edge. Soft request is a pulse.
  task automatic run_table(input int ncyc, input string name);
    for (int c = 0; c < ncyc; c++) begin
      ifa.i_soft_reset_req = 1'b0;
      ifb.i_soft_reset_req = 1'b0;
      foreach (tbl[k]) begin
        if (tbl[k].cyc == c) begin
          set_in(tbl[k].dut, tbl[k].lk, tbl[k].mr);
          if (!tbl[k].dut) ifa.i_soft_reset_req = tbl[k].sr;
          else             ifb.i_soft_reset_req = tbl[k].sr;
        end
      end
      @(negedge clk);
      foreach (tbl[k]) begin
        if (tbl[k].cyc == c) check_vec(tbl[k], name);
      end
      @(posedge clk);
      #1;
    end
    ifa.i_soft_reset_req = 1'b0;
    ifb.i_soft_reset_req = 1'b0;
    tbl.delete();
  endtask

  localparam logic [5:0] ALL = 6'b111111;
  localparam logic [5:0] NONE = 6'b000000;

  initial begin
    ifa.i_soft_reset_req = 1'b0; ifb.i_soft_reset_req = 1'b0;
    set_in(0, 1'b1, 1'b1);
    set_in(1, 1'b1, 1'b0);

    // Power-up release order (A), lock-loss rerun (A), lock timeout and recovery (B)
    do_reset(1'b0);
    add(0,  0, 1, 1, 0, ALL,       1, 0, 0);
    add(16, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(17, 0, 1, 1, 0, 6'b111110, 1, 0, 0);
    add(20, 0, 1, 1, 0, 6'b111110, 1, 0, 0);
    add(21, 0, 1, 1, 0, 6'b111100, 1, 0, 0);
    add(25, 0, 1, 1, 0, 6'b111000, 1, 0, 0);
    add(29, 0, 1, 1, 0, 6'b110000, 1, 0, 0);
    add(33, 0, 1, 1, 0, 6'b100000, 1, 0, 0);
    add(36, 0, 1, 1, 0, 6'b100000, 1, 0, 0);
    add(37, 0, 1, 1, 0, NONE,      1, 0, 0);
    add(40, 0, 1, 1, 0, NONE,      1, 0, 0);
    add(41, 0, 1, 1, 0, NONE,      0, 1, 0);
    add(45, 0, 0, 1, 0, NONE,      0, 1, 0);
    add(46, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(61, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(62, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(63, 0, 1, 1, 0, 6'b111110, 1, 0, 0);
    add(83, 0, 1, 1, 0, NONE,      1, 0, 0);
    add(86, 0, 1, 1, 0, NONE,      1, 0, 0);
    add(87, 0, 1, 1, 0, NONE,      0, 1, 0);
    add(0,  1, 1, 0, 0, ALL,       1, 0, 0);
    add(79, 1, 1, 0, 0, ALL,       1, 0, 0);
    add(80, 1, 1, 0, 0, ALL,       1, 0, 1);
    add(81, 1, 1, 1, 0, ALL,       1, 0, 1);
    add(90, 1, 1, 1, 0, ALL,       1, 0, 1);
    add(91, 1, 1, 1, 1, ALL,       1, 0, 1);
    add(92, 1, 1, 1, 0, ALL,       1, 0, 0);
    add(107,1, 1, 1, 0, ALL,       1, 0, 0);
    add(108,1, 1, 1, 0, ALL,       1, 0, 0);
    add(109,1, 1, 1, 0, 6'b111110, 1, 0, 0);
    run_table(110, "seq_lockloss_timeout");

    // Late memory calibration (A)
    set_in(0, 1'b1, 1'b0);
    set_in(1, 1'b1, 1'b1);
    do_reset(1'b0);
    add(0,   0, 1, 0, 0, ALL,       1, 0, 0);
    add(50,  0, 1, 0, 0, ALL,       1, 0, 0);
    add(100, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(101, 0, 1, 1, 0, 6'b111110, 1, 0, 0);
    add(105, 0, 1, 1, 0, 6'b111100, 1, 0, 0);
    add(121, 0, 1, 1, 0, NONE,      1, 0, 0);
    add(124, 0, 1, 1, 0, NONE,      1, 0, 0);
    add(125, 0, 1, 1, 0, NONE,      0, 1, 0);
    run_table(126, "late_mem_ready");

    // Soft request one cycle after design_ic releases (A)
    set_in(0, 1'b1, 1'b1);
    do_reset(1'b0);
    add(25, 0, 1, 1, 0, 6'b111000, 1, 0, 0);
    add(26, 0, 1, 1, 1, 6'b111000, 1, 0, 0);
    add(27, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(42, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(43, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(44, 0, 1, 1, 0, 6'b111110, 1, 0, 0);
    add(48, 0, 1, 1, 0, 6'b111100, 1, 0, 0);
    run_table(49, "soft_mid_release");

    // Reset together with soft request, mid-operation on A, in ERROR on B
    set_in(1, 1'b1, 1'b0);
    do_reset(1'b0);
    add(30, 0, 1, 1, 0, 6'b110000, 1, 0, 0);
    add(84, 1, 1, 0, 0, ALL,       1, 0, 1);
    run_table(85, "pre_reset_soft");
    do_reset(1'b1);
    add(0,  0, 1, 1, 0, ALL,       1, 0, 0);
    add(16, 0, 1, 1, 0, ALL,       1, 0, 0);
    add(17, 0, 1, 1, 0, 6'b111110, 1, 0, 0);
    add(0,  1, 1, 0, 0, ALL,       1, 0, 0);
    add(20, 1, 1, 0, 0, ALL,       1, 0, 0);
    run_table(21, "reset_with_soft");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_reset_sequencer.md
Name: clock_reset_sequencer

Overview:
- Generates the host, design and memory reset pairs (peripheral and interconnect, each in both polarities) that feed the clocks/resets slave bridge.
- On power-up, on a software request, or when a clock/memory lock is lost:
  - asserts all resets;
  - holds them for a minimum time;
  - waits for the design MMCM lock and memory calibration;
  - releases the resets one at a time in a fixed order.
- Single clock domain, on the host clock.

Parameters:
- HOLD_CYCLES, 16, minimum cycles all resets stay asserted after entering ASSERT (>=1).
- STAGE_GAP, 4, cycles between consecutive release steps (>=1).
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before error (>=1).

Ports:
- i_clk  in  1  host clock.
- i_reset  in  1  synchronous, active-high reset.
- i_soft_reset_req  in  1  single-cycle request to re-run the full sequence.
- i_design_locked  in  1  design clock MMCM locked.
- i_mem_ready  in  1  memory controller calibrated.
- o_host_interconnect_reset / o_host_interconnect_resetn  out  1 each.
- o_mem_interconnect_reset / o_mem_interconnect_resetn  out  1 each.
- o_design_interconnect_reset / o_design_interconnect_resetn  out  1 each.
- o_host_peripheral_reset / o_host_peripheral_resetn  out  1 each.
- o_mem_peripheral_reset / o_mem_peripheral_resetn  out  1 each.
- o_design_peripheral_reset / o_design_peripheral_resetn  out  1 each.
- o_busy  out  1  sequence in progress (any state except DONE).
- o_done  out  1  all resets released.
- o_timeout  out  1  sticky lock-timeout error.

Behaviour:
- **Registers:** state, one counter sized for max(HOLD_CYCLES, STAGE_GAP, LOCK_TIMEOUT), and a 6-bit release mask.
  - Mask bit order: 0 host_ic, 1 mem_ic, 2 design_ic, 3 host_periph, 4 mem_periph, 5 design_periph.
  - Each reset output = NOT mask bit. Each resetn output = mask bit.
  - All outputs are registered, with no combinational path from inputs.
  - Invariant, every cycle: reset == ~resetn.
- **Reset (i_reset=1):**
  - state=ASSERT, counter=0, mask=0.
  - All resets asserted.
  - o_busy=1, o_done=0, o_timeout=0.
- **ASSERT:**
  - Counter counts 0..HOLD_CYCLES-1, starting in the first cycle i_reset is low.
  - At count HOLD_CYCLES-1 → WAIT_LOCK, counter=0.
- **WAIT_LOCK:**
  - If i_design_locked & i_mem_ready: → RELEASE; in the same edge set mask bit0 and set counter=0.
  - Else counter++. At count LOCK_TIMEOUT-1 → ERROR.
  - Locks are sampled level-only; no debounce.
- **RELEASE:**
  - Counter counts 0..STAGE_GAP-1 after each mask bit is set.
  - At STAGE_GAP-1, set the next mask bit.
  - After bit5 has been set and the gap has elapsed → DONE.
- **DONE:** o_busy=0, o_done=1, mask=6'b111111.
- **ERROR:**
  - mask=0, o_timeout=1, o_busy=1.
  - Stays in ERROR regardless of the lock inputs.
  - Exits only via i_soft_reset_req or i_reset.
- **Lock loss:**
  - In RELEASE or DONE, if i_design_locked=0 or i_mem_ready=0 → ASSERT next edge.
  - On that edge: mask=0 (all resets asserted on the following cycle), counter=0, o_done=0.
- **Soft request:**
  - In any state → ASSERT, mask=0, counter=0, o_timeout cleared.
  - In ASSERT it restarts the hold count.
- **Priority:** i_reset > i_soft_reset_req > lock loss > normal progression.
- **Reset mid-operation:** identical to power-up.

Test Plan:
1. Power-up with defaults, locks high throughout, i_reset high for 2 cycles; call the first cycle with i_reset low cycle 0.
   - All resets asserted for cycles 0..16.
   - Resets deassert in order host_ic@17, mem_ic@21, design_ic@25, host_periph@29, mem_periph@33, design_periph@37.
   - o_done=1 and o_busy=0 @41.
2. Same as 1 but i_mem_ready rises at cycle 100 → host_ic deasserts @101, then the remaining steps every 4 cycles; o_done @125.
3. LOCK_TIMEOUT=64, i_mem_ready held low:
   - o_timeout=1 @80 (16+64), all resets stay asserted.
   - Raising i_mem_ready changes nothing.
   - i_soft_reset_req pulse → o_timeout=0 next cycle, hold restarts.
4. In DONE, drop i_design_locked for 1 cycle:
   - All 12 outputs return to their asserted values one cycle later; o_done=0.
   - Full sequence reruns: 16 hold cycles, then release once the lock returns.
5. i_soft_reset_req pulse one cycle after design_ic deasserts:
   - All resets reasserted next cycle.
   - Full 16-cycle hold, then host_ic releases again first.
6. i_reset and i_soft_reset_req high in the same cycle → same result as reset. Assert reset == ~resetn for all six pairs every cycle across all tests.
